// File: rtl/demux_seq.sv
// Serial-to-parallel channel demultiplexer with an auto-advancing channel counter.
// Optional macro DEMUX_SEQ_SHADOW_EN double-buffers q and updates it once per frame.
module demux_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       d,
  input  logic       strobe,
  input  logic       ng,
  input  logic       load,
  input  logic [2:0] sel,
  input  logic       clr,
  output logic [7:0] q,
  output logic [2:0] ch,
  output logic       frame
);

  logic [7:0] q_r;
  logic [2:0] ch_r;
  logic       frame_r;
  logic       gate_s;
  logic       wr_s;
  logic       ld_s;
  logic [2:0] target_s;
  logic [7:0] base_s;
  logic [7:0] next_bits_s;

`ifdef DEMUX_SEQ_SHADOW_EN
  logic [7:0] shadow_r;
  assign base_s = shadow_r;
`else
  assign base_s = q_r;
`endif

  // Decode this edge's write/load and the bit image after the write.
  // The (x | ~x) terms make an unknown strobe or load poison the gate in simulation.
  always_comb begin
    gate_s      = ~ng & (strobe | ~strobe) & (load | ~load);
    wr_s        = strobe & gate_s;
    ld_s        = load & gate_s;
    if (ld_s) begin
      target_s = sel;
    end else begin
      target_s = ch_r;
    end
    next_bits_s           = base_s;
    next_bits_s[target_s] = d;
  end

  // Channel, data and frame state; reset beats clr beats write/load beats hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r     <= 8'h00;
      ch_r    <= 3'd0;
      frame_r <= 1'b0;
`ifdef DEMUX_SEQ_SHADOW_EN
      shadow_r <= 8'h00;
`endif
    end else if (clr) begin
      q_r     <= 8'h00;
      ch_r    <= 3'd0;
      frame_r <= 1'b0;
`ifdef DEMUX_SEQ_SHADOW_EN
      shadow_r <= 8'h00;
`endif
    end else if (wr_s) begin
      ch_r    <= target_s + 3'd1;
      frame_r <= (target_s == 3'd7);
`ifdef DEMUX_SEQ_SHADOW_EN
      shadow_r <= next_bits_s;
      // Publish the completed frame, channel 7 included, together with frame.
      if (target_s == 3'd7) begin
        q_r <= next_bits_s;
      end else begin
        q_r <= q_r;
      end
`else
      q_r <= next_bits_s;
`endif
    end else if (ld_s) begin
      ch_r    <= sel;
      frame_r <= 1'b0;
    end else begin
      frame_r <= 1'b0;
    end
  end

  assign q     = q_r;
  assign ch    = ch_r;
  assign frame = frame_r;

endmodule

// File: tb/tb_demux_seq.sv
// Table-driven bench for demux_seq; expectations cover both DEMUX_SEQ_SHADOW_EN builds.
module tb_demux_seq;

  logic       clk;
  logic       reset;
  logic       d;
  logic       strobe;
  logic       ng;
  logic       load;
  logic [2:0] sel;
  logic       clr;
  logic [7:0] q;
  logic [2:0] ch;
  logic       frame;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       ng;
    logic       load;
    logic       strobe;
    logic       d;
    logic [2:0] sel;
    logic [7:0] qd;   // expected q, direct build
    logic [7:0] qs;   // expected q, shadow build
    logic [2:0] ech;
    logic       efr;
  } vec_t;

  vec_t vecs[$];

  demux_seq dut (
    .clk    (clk),
    .reset  (reset),
    .d      (d),
    .strobe (strobe),
    .ng     (ng),
    .load   (load),
    .sel    (sel),
    .clr    (clr),
    .q      (q),
    .ch     (ch),
    .frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic c, logic n, logic l, logic s, logic dd,
                              logic [2:0] sl, logic [7:0] qd, logic [7:0] qs,
                              logic [2:0] ec, logic ef);
    vec_t v;
    v.rst = r; v.clr = c; v.ng = n; v.load = l; v.strobe = s; v.d = dd; v.sel = sl;
    v.qd = qd; v.qs = qs; v.ech = ec; v.efr = ef;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [7:0] exp_q;
    @(negedge clk);
    reset = v.rst; clr = v.clr; ng = v.ng; load = v.load;
    strobe = v.strobe; d = v.d; sel = v.sel;
    @(posedge clk);
    #1;
`ifdef DEMUX_SEQ_SHADOW_EN
    exp_q = v.qs;
`else
    exp_q = v.qd;
`endif
    checks++;
    if (q !== exp_q) begin
      errors++;
      $display("FAIL: %s q t=%0t got=%h exp=%h", name, $time, q, exp_q);
    end
    checks++;
    if (ch !== v.ech) begin
      errors++;
      $display("FAIL: %s ch t=%0t got=%0d exp=%0d", name, $time, ch, v.ech);
    end
    checks++;
    if (frame !== v.efr) begin
      errors++;
      $display("FAIL: %s frame t=%0t got=%b exp=%b", name, $time, frame, v.efr);
    end
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; ng = 1'b0; load = 1'b0;
    strobe = 1'b0; d = 1'b0; sel = 3'd0;

    //                rst   clr   ng    load  strb  d     sel   q_dir  q_shd  ch    frame
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 8'h00, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 8'h00, 3'd2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h05, 8'h00, 3'd3, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h0D, 8'h00, 3'd4, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h0D, 8'h00, 3'd5, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h0D, 8'h00, 3'd6, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h4D, 8'h00, 3'd7, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h4D, 8'h4D, 3'd0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h4D, 8'h4D, 3'd0, 1'b0));
    // load 5, then writes at 5, 6, 7
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h4D, 8'h4D, 3'd5, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h6D, 8'h4D, 3'd6, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h2D, 8'h4D, 3'd7, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hAD, 8'hAD, 3'd0, 1'b1));
    // clr wins over load and strobe
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h00, 8'h00, 3'd0, 1'b0));
    // load+strobe to channel 7
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 8'h80, 3'd0, 1'b1));
    // ng blocks everything
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 8'h80, 8'h80, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'bx, 1'bx, 1'bx, 1'b1, 3'd2, 8'h80, 8'h80, 3'd0, 1'b0));
    // 3 writes then reset mid-frame (with clr/load/strobe also high)
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h81, 8'h80, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h83, 8'h80, 3'd2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h87, 8'h80, 3'd3, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 8'h00, 8'h00, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 8'h00, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h03, 8'h00, 3'd2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h07, 8'h00, 3'd3, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h0F, 8'h00, 3'd4, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h1F, 8'h00, 3'd5, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h3F, 8'h00, 3'd6, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h7F, 8'h00, 3'd7, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hFF, 8'hFF, 3'd0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 8'h00, 3'd0, 1'b0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Hand sequence: frame is a single-cycle pulse even with back-to-back writes across the wrap.
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40, 8'h00, 3'd7, 1'b0), "wrap_ld6");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hC0, 8'hC0, 3'd0, 1'b1), "wrap_w7");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'hC0, 8'hC0, 3'd1, 1'b0), "wrap_w0");

    // Hand sequence: load without strobe after a frame pulse drops frame and keeps data.
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 8'hC0, 8'hC0, 3'd0, 1'b1), "ld7_w");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'hC0, 8'hC0, 3'd2, 1'b0), "ld2_only");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (errors == 0) $display("OK");
    $finish;
  end

endmodule
